// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch-side PC sequencer
package pc_seq_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Source chosen for the next program counter
    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JALR = 2'd2,
        SRC_TRAP = 2'd3
    } pc_src_e;

    // Byte distance between consecutive instructions
    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory request/ready handshake bundle
interface pc_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32
) ();

    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_ready;

    // Sequencer side drives the request and address
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    // Memory side answers with ready
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority select (trap > jalr > branch > sequential); PC_MISALIGN_TRAP_EN
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic                     branch_taken_i,
    input  logic [ADDRESS_WIDTH-1:0] imm_op_i,
    input  logic                     jalr_i,
    input  logic [ADDRESS_WIDTH-1:0] jalr_target_i,
    input  logic                     trap_i,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                     misalign_o,
`endif
    output logic [ADDRESS_WIDTH-1:0] target_o,
    output pc_src_e                  src_o
);

    logic [ADDRESS_WIDTH-1:0] raw_target;

    // Pick the highest-priority source and form its raw target (sums wrap silently)
    always_comb begin
        src_o      = SRC_SEQ;
        raw_target = pc_i + ADDRESS_WIDTH'(PC_INCR);
        if (trap_i) begin
            src_o      = SRC_TRAP;
            raw_target = TRAP_VECTOR;
        end else if (jalr_i) begin
            src_o      = SRC_JALR;
            raw_target = {jalr_target_i[ADDRESS_WIDTH-1:1], 1'b0};
        end else if (branch_taken_i) begin
            src_o      = SRC_BR;
            raw_target = pc_i + imm_op_i;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned redirect is turned into a trap to the vector
    always_comb begin
        misalign_o = (src_o != SRC_SEQ) && (raw_target[1:0] != 2'b00);
        target_o   = misalign_o ? TRAP_VECTOR : raw_target;
    end
`else
    // Low address bits are simply forced to word alignment
    always_comb begin
        target_o = {raw_target[ADDRESS_WIDTH-1:2], 2'b00};
    end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC owner and instruction-fetch sequencer; optional PC_MISALIGN_TRAP_EN
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     branch_taken_i,
    input  logic [ADDRESS_WIDTH-1:0] imm_op_i,
    input  logic                     jalr_i,
    input  logic [ADDRESS_WIDTH-1:0] jalr_target_i,
    input  logic                     trap_i,
    input  logic                     halt_i,
    pc_sequencer_if.master           imem,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic                     pc_valid_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                     misalign_o,
`endif
    output logic                     redirect_o
);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     pend_q, pend_d;
    logic [ADDRESS_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic                     halt_pend_q, halt_pend_d;

    logic [ADDRESS_WIDTH-1:0] sel_target;
    pc_src_e                  sel_src;
    logic                     sel_redirect;
    logic                     halt_req;
    logic                     req;
    logic                     pc_valid;
    logic                     redirect;
`ifdef PC_MISALIGN_TRAP_EN
    logic                     sel_misalign;
`endif

    pc_next_sel #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .TRAP_VECTOR   (TRAP_VECTOR)
    ) u_next_sel (
        .pc_i           (pc_q),
        .branch_taken_i (branch_taken_i),
        .imm_op_i       (imm_op_i),
        .jalr_i         (jalr_i),
        .jalr_target_i  (jalr_target_i),
        .trap_i         (trap_i),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_o     (sel_misalign),
`endif
        .target_o       (sel_target),
        .src_o          (sel_src)
    );

    assign sel_redirect = (sel_src != SRC_SEQ);
    // A trap in the same cycle overrides a halt request
    assign halt_req     = halt_i && !trap_i;

    // State, PC and pending-redirect registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_q      <= 1'b0;
            pend_tgt_q  <= RESET_VECTOR;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Next-state, handshake and delivery decisions
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        halt_pend_d = halt_pend_q;
        req         = 1'b0;
        pc_valid    = 1'b0;
        redirect    = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else begin
                    // A redirect still happens under stall; only the request is withheld
                    req      = !stall_i;
                    redirect = sel_redirect;
                    if (req && imem.imem_ready) begin
                        pc_valid = !sel_redirect;
                        pc_d     = sel_target;
                    end else if (req) begin
                        // Address must stay put until accepted, so park any redirect
                        state_d    = WAIT;
                        pend_d     = sel_redirect;
                        pend_tgt_d = sel_target;
                    end else if (sel_redirect) begin
                        pc_d = sel_target;
                    end
                end
            end

            WAIT: begin
                req      = 1'b1;
                redirect = sel_redirect;
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (trap_i) begin
                    halt_pend_d = 1'b0;
                end
                if (imem.imem_ready) begin
                    pc_valid    = !sel_redirect && !pend_q;
                    if (sel_redirect || !pend_q) begin
                        pc_d = sel_target;
                    end else begin
                        pc_d = pend_tgt_q;
                    end
                    pend_d      = 1'b0;
                    halt_pend_d = 1'b0;
                    state_d     = ((halt_pend_q || halt_i) && !trap_i) ? HALTED : FETCH;
                end else if (sel_redirect) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = sel_target;
                end
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign pc_valid_o     = pc_valid;
    assign redirect_o     = redirect;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o     = redirect && sel_misalign;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller that owns the program counter and sequences instruction fetch.
- Picks the next PC from four sources: sequential, branch (PC+imm), JALR and trap vector.
- Applies hazard-unit stalls and runs a valid/ready handshake to instruction memory.
- Sits between the decode/hazard logic and the PC register/mux datapath; emits a redirect pulse the pipeline uses to flush.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and all addresses.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0080, PC loaded on trap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold current PC, no new fetch.
- branch_taken  in  1  taken conditional branch (PCsrc).
- imm_op  in  ADDRESS_WIDTH  branch offset, two's complement.
- jalr  in  1  jump-register redirect.
- jalr_target  in  ADDRESS_WIDTH  rs1+imm from ALU.
- trap  in  1  exception request.
- halt  in  1  stop fetching (ebreak).
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDRESS_WIDTH  fetch address.
- imem_ready  in  1  memory accepts/returns this cycle.
- pc  out  ADDRESS_WIDTH  PC of instruction delivered this cycle.
- pc_valid  out  1  fetched word valid, pulse per instruction.
- redirect  out  1  one-cycle flush pulse to pipeline.

Behaviour:
- Reset (rst=0, async): state=BOOT, pc_q=RESET_VECTOR, imem_req=0, pc_valid=0, redirect=0, pending redirect cleared.
- FSM states: BOOT, FETCH, WAIT, HALTED.
- BOOT: one idle cycle after reset release, then go to FETCH. No request in BOOT.
- FETCH:
  - imem_req = !stall; imem_addr = pc_q.
  - req && ready: pc_valid=1, pc=pc_q, pc_q<=next, stay in FETCH.
  - req && !ready: go to WAIT.
- WAIT:
  - imem_req=1; imem_addr held stable until ready (handshake rule: address never changes while req is high without ready).
  - On ready: deliver the word (pc_valid=1), pc_q<=next, go to FETCH.
- Next-PC priority: trap > jalr > branch_taken > sequential.
  - Trap: TRAP_VECTOR.
  - JALR: jalr_target with bit0 cleared.
  - Branch: pc_q+imm_op.
  - Sequential: pc_q+4.
  - All sums are modulo 2^ADDRESS_WIDTH; wrap from 32'hFFFF_FFFC to 0 is silent.
- Redirect (trap/jalr/branch) in FETCH:
  - redirect=1 for that cycle.
  - Any word returned that cycle is dropped (pc_valid=0).
  - pc_q<=target.
- Redirect in WAIT:
  - redirect=1 that cycle; target latched as pending.
  - imem_addr stays stable.
  - On ready: word dropped, pc_q<=pending target, go to FETCH.
  - A later redirect before ready overwrites pending.
- Stall:
  - pc_q holds; no new request issued.
  - A request already in WAIT continues (stall does not withdraw imem_req).
  - Stall together with redirect: redirect wins.
- Halt:
  - Sampled in FETCH or WAIT.
  - FETCH: go to HALTED immediately. WAIT: finish the outstanding fetch, then go to HALTED.
  - HALTED: imem_req=0, pc_valid=0; only reset exits.
  - Trap has priority over halt in the same cycle.
- Reset mid-WAIT: request dropped asynchronously, imem_req=0.
- pc_valid and redirect are never both 1.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with target[1:0]!=0 is replaced by TRAP_VECTOR.
  - Adds output misalign (1 bit, one-cycle pulse), asserted alongside redirect.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - No misalign port.

Decomposition:
- Package pc_seq_pkg:
  - state enum (BOOT, FETCH, WAIT, HALTED).
  - next-PC source enum (SRC_SEQ, SRC_BR, SRC_JALR, SRC_TRAP).
  - constant PC_INCR=4.
- One sub-module, pc_next_sel: combinational priority select plus adders producing target and source. The FSM stays in pc_sequencer.

Test Plan:
- Reset release, ready tied 1 → first req at cycle 2 with addr 0; pc_valid pulses pc=0,4,8,12 on consecutive cycles.
- branch_taken=1, imm_op=-8, pc_q=0x10 → redirect pulse, word dropped, next imem_addr=0x08.
- ready low 3 cycles with jalr=1, target 0x101, in the first WAIT cycle → addr held; word dropped on ready; next addr=0x100.
- stall high 2 cycles at pc 0x20 → imem_req=0 for both cycles; resumes at 0x20 with no skipped or duplicated pc_valid.
- trap and branch in the same cycle → next addr=0x80; halt → imem_req stays 0 until rst pulse, then fetch resumes at RESET_VECTOR.
- With PC_MISALIGN_TRAP_EN defined, branch to 0x22 → misalign pulse, next addr=0x80.
